// File: rtl/arp_resolve_ctrl.sv
// IP->MAC resolution sequencer: ARP table lookup first, then active ARP requests
// with per-request reply timeout and bounded retries.
module arp_resolve_ctrl #(
   parameter int P_LOOKUP_TO = 16,
   parameter int P_REPLY_TO  = 125_000_000,
   parameter int P_RETRY     = 3,
   parameter int P_TIMER_W   = 32
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [31:0] i_req_ip,
   input  logic        i_req_valid,
   output logic        o_req_busy,
   output logic [47:0] o_resolve_mac,
   output logic        o_resolve_valid,
   output logic        o_resolve_fail,
   output logic [31:0] o_seek_ip,
   output logic        o_seek_valid,
   input  logic [47:0] i_tab_mac,
   input  logic        i_tab_valid,
   output logic        o_arp_req,
   output logic [31:0] o_arp_dst_ip,
   input  logic        i_arp_tx_busy,
   input  logic [31:0] i_rx_ip,
   input  logic [47:0] i_rx_mac,
   input  logic        i_rx_valid
);

   localparam int RW = $clog2(P_RETRY + 1);
   localparam logic [P_TIMER_W-1:0] LOOKUP_END = P_TIMER_W'(P_LOOKUP_TO - 1);
   localparam logic [P_TIMER_W-1:0] REPLY_END  = P_TIMER_W'(P_REPLY_TO - 1);
   localparam logic [RW-1:0]        RETRY_MAX  = RW'(P_RETRY);

   typedef enum logic [2:0] {
      IDLE, SEEK, WAIT_TAB, ARP_REQ, WAIT_REPLY, DONE, FAIL
   } state_t;

   state_t                 state;
   logic [P_TIMER_W-1:0]   timer;
   logic [RW-1:0]          retry;
   logic                   rx_match;

   // o_arp_dst_ip doubles as the latched target for reply matching
   assign rx_match = i_rx_valid && (i_rx_ip == o_arp_dst_ip);

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state           <= IDLE;
         timer           <= '0;
         retry           <= '0;
         o_req_busy      <= 1'b0;
         o_resolve_mac   <= '0;
         o_resolve_valid <= 1'b0;
         o_resolve_fail  <= 1'b0;
         o_seek_ip       <= '0;
         o_seek_valid    <= 1'b0;
         o_arp_req       <= 1'b0;
         o_arp_dst_ip    <= '0;
      end else begin
         o_seek_valid    <= 1'b0;
         o_arp_req       <= 1'b0;
         o_resolve_valid <= 1'b0;
         o_resolve_fail  <= 1'b0;
         case (state)
            IDLE: begin
               if (i_req_valid) begin
                  o_seek_ip    <= i_req_ip;
                  o_arp_dst_ip <= i_req_ip;
                  retry        <= '0;
                  o_req_busy   <= 1'b1;
                  o_seek_valid <= 1'b1;
                  state        <= SEEK;
               end
            end
            SEEK: begin
               timer <= '0;
               state <= WAIT_TAB;
            end
            WAIT_TAB: begin
               if (rx_match) begin
                  o_resolve_mac   <= i_rx_mac;
                  o_resolve_valid <= 1'b1;
                  state           <= DONE;
               end else if (i_tab_valid && i_tab_mac != '0) begin
                  o_resolve_mac   <= i_tab_mac;
                  o_resolve_valid <= 1'b1;
                  state           <= DONE;
               end else if (i_tab_valid || timer == LOOKUP_END) begin
                  state <= ARP_REQ;
               end else begin
                  timer <= timer + P_TIMER_W'(1);
               end
            end
            ARP_REQ: begin
               if (rx_match) begin
                  o_resolve_mac   <= i_rx_mac;
                  o_resolve_valid <= 1'b1;
                  state           <= DONE;
               end else if (!i_arp_tx_busy) begin
                  o_arp_req <= 1'b1;
                  retry     <= retry + RW'(1);
                  timer     <= '0;
                  state     <= WAIT_REPLY;
               end
            end
            WAIT_REPLY: begin
               if (rx_match) begin
                  o_resolve_mac   <= i_rx_mac;
                  o_resolve_valid <= 1'b1;
                  state           <= DONE;
               end else if (timer == REPLY_END) begin
                  if (retry == RETRY_MAX) begin
                     o_resolve_fail <= 1'b1;
                     state          <= FAIL;
                  end else begin
                     state <= ARP_REQ;
                  end
               end else begin
                  timer <= timer + P_TIMER_W'(1);
               end
            end
            DONE, FAIL: begin
               o_req_busy <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_arp_resolve_ctrl.sv
// Directed scoreboard bench for arp_resolve_ctrl: lookup hit, ARP miss/reply,
// retries to failure, TX-busy stall, match/timeout race and mid-operation reset.
module tb_arp_resolve_ctrl;
   localparam int LK = 8, RT = 100, RTRY = 3;

   logic        i_clk, i_rst;
   logic [31:0] i_req_ip;
   logic        i_req_valid;
   logic        o_req_busy;
   logic [47:0] o_resolve_mac;
   logic        o_resolve_valid, o_resolve_fail;
   logic [31:0] o_seek_ip;
   logic        o_seek_valid;
   logic [47:0] i_tab_mac;
   logic        i_tab_valid;
   logic        o_arp_req;
   logic [31:0] o_arp_dst_ip;
   logic        i_arp_tx_busy;
   logic [31:0] i_rx_ip;
   logic [47:0] i_rx_mac;
   logic        i_rx_valid;

   arp_resolve_ctrl #(.P_LOOKUP_TO(LK), .P_REPLY_TO(RT), .P_RETRY(RTRY), .P_TIMER_W(32)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_req_ip(i_req_ip), .i_req_valid(i_req_valid),
      .o_req_busy(o_req_busy), .o_resolve_mac(o_resolve_mac), .o_resolve_valid(o_resolve_valid),
      .o_resolve_fail(o_resolve_fail), .o_seek_ip(o_seek_ip), .o_seek_valid(o_seek_valid),
      .i_tab_mac(i_tab_mac), .i_tab_valid(i_tab_valid), .o_arp_req(o_arp_req),
      .o_arp_dst_ip(o_arp_dst_ip), .i_arp_tx_busy(i_arp_tx_busy), .i_rx_ip(i_rx_ip),
      .i_rx_mac(i_rx_mac), .i_rx_valid(i_rx_valid)
   );

   typedef struct { bit fail; logic [47:0] mac; int rel; } res_t;
   typedef struct { int rel; logic [31:0] dst; } arp_t;

   res_t exp_q[$];
   res_t res_q[$];
   arp_t arp_q[$];
   int   cyc = 0, t_req = 0, seek_cnt = 0;
   int   res_rd = 0, arp_rd = 0, seek_base = 0;
   int   vectors = 0, miscompares = 0;

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   always @(posedge i_clk) cyc <= cyc + 1;

   // Output monitor; times are cycles relative to the accepted request cycle
   always @(negedge i_clk) begin
      if (o_seek_valid) seek_cnt = seek_cnt + 1;
      if (o_arp_req) arp_q.push_back('{rel: cyc - t_req, dst: o_arp_dst_ip});
      if (o_resolve_valid || o_resolve_fail)
         res_q.push_back('{fail: o_resolve_fail, mac: o_resolve_mac, rel: cyc - t_req});
   end

   task automatic step(input int n);
      repeat (n) begin @(posedge i_clk); #1; end
   endtask

   task automatic to_rel(input int r);
      while (cyc - t_req < r) step(1);
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive_req(input logic [31:0] ip);
      i_req_ip = ip; i_req_valid = 1'b1; t_req = cyc;
      seek_base = seek_cnt;
      step(1);
      i_req_valid = 1'b0;
   endtask

   task automatic tab(input logic [47:0] mac);
      i_tab_mac = mac; i_tab_valid = 1'b1; step(1); i_tab_valid = 1'b0;
   endtask

   task automatic rx(input logic [31:0] ip, input logic [47:0] mac);
      i_rx_ip = ip; i_rx_mac = mac; i_rx_valid = 1'b1; step(1); i_rx_valid = 1'b0;
   endtask

   task automatic expect_res(input bit f, input logic [47:0] mac, input int rel);
      exp_q.push_back('{fail: f, mac: mac, rel: rel});
   endtask

   task automatic check_res(input string tag, input int budget);
      int   n;
      res_t r, e;
      n = 0;
      while (res_q.size() <= res_rd && n < budget) begin step(1); n++; end
      if (res_q.size() <= res_rd) begin
         chk({tag, " result timeout"}, 64'd0, 64'd1);
         if (exp_q.size() > 0) void'(exp_q.pop_front());
         return;
      end
      r = res_q[res_rd];
      res_rd++;
      e = exp_q.pop_front();
      chk({tag, " fail flag"}, 64'(r.fail), 64'(e.fail));
      if (!e.fail) chk({tag, " mac"}, 64'(r.mac), 64'(e.mac));
      chk({tag, " result cycle"}, 64'(r.rel), 64'(e.rel));
      chk({tag, " busy after"}, 64'(o_req_busy), 64'd0);
   endtask

   task automatic check_arp(input string tag, input int n, input int t0, input int gap,
                            input logic [31:0] ip);
      chk({tag, " arp count"}, 64'(arp_q.size() - arp_rd), 64'(n));
      for (int i = 0; i < n && arp_rd + i < arp_q.size(); i++) begin
         chk({tag, " arp cycle"}, 64'(arp_q[arp_rd + i].rel), 64'(t0 + i * gap));
         chk({tag, " arp dst"}, 64'(arp_q[arp_rd + i].dst), 64'(ip));
      end
      arp_rd = arp_q.size();
   endtask

   initial begin
      i_rst = 1'b0; i_req_ip = '0; i_req_valid = 1'b0; i_tab_mac = '0; i_tab_valid = 1'b0;
      i_arp_tx_busy = 1'b0; i_rx_ip = '0; i_rx_mac = '0; i_rx_valid = 1'b0;
      step(3);
      chk("reset busy", 64'(o_req_busy), 64'd0);
      chk("reset outputs", 64'({o_resolve_valid, o_resolve_fail, o_seek_valid, o_arp_req}), 64'd0);
      chk("reset mac", 64'(o_resolve_mac), 64'd0);
      i_rst = 1'b1;
      step(2);

      // 1: table hit two cycles after the seek strobe
      drive_req(32'hC0A80A00);
      chk("t1 seek strobe", 64'(o_seek_valid), 64'd1);
      chk("t1 seek ip", 64'(o_seek_ip), 64'hC0A80A00);
      chk("t1 busy", 64'(o_req_busy), 64'd1);
      expect_res(1'b0, 48'h112233445566, 4);
      to_rel(3); tab(48'h112233445566);
      check_res("t1", 20);
      check_arp("t1", 0, 0, 0, 32'h0);
      chk("t1 seek count", 64'(seek_cnt - seek_base), 64'd1);

      // 2: table miss, reply 40 cycles after the ARP request
      drive_req(32'hC0A80A00);
      expect_res(1'b0, 48'hAABBCCDDEEFF, 46);
      to_rel(3); tab(48'h0);
      to_rel(45); rx(32'hC0A80A00, 48'hAABBCCDDEEFF);
      check_res("t2", 20);
      check_arp("t2", 1, 5, 0, 32'hC0A80A00);

      // 3: no reply at all; request re-issued after each reply window, then fail
      drive_req(32'hC0A80A01);
      expect_res(1'b1, 48'h0, 5 + 2 * (RT + 1) + RT);
      to_rel(3); tab(48'h0);
      check_res("t3", 400);
      check_arp("t3", RTRY, 5, RT + 1, 32'hC0A80A01);

      // 4: silent table, ARP TX busy for 20 cycles, foreign reply ignored
      drive_req(32'hC0A80A02);
      expect_res(1'b0, 48'h0A0B0C0D0E0F, 51);
      to_rel(10); i_arp_tx_busy = 1'b1;
      to_rel(20); rx(32'hC0A80A05, 48'hDEADBEEF0001);
      to_rel(30); i_arp_tx_busy = 1'b0;
      to_rel(40); rx(32'hC0A80A05, 48'hDEADBEEF0002);
      to_rel(50); rx(32'hC0A80A02, 48'h0A0B0C0D0E0F);
      check_res("t4", 20);
      check_arp("t4", 1, 11 + 20, 0, 32'hC0A80A02);

      // 5: reply lands on the timeout cycle; a request while busy is dropped
      drive_req(32'hC0A80A03);
      expect_res(1'b0, 48'h665544332211, 5 + RT);
      to_rel(3); tab(48'h0);
      to_rel(50);
      i_req_ip = 32'hC0A80A09; i_req_valid = 1'b1; step(1); i_req_valid = 1'b0;
      to_rel(5 + RT - 1); rx(32'hC0A80A03, 48'h665544332211);
      check_res("t5", 20);
      check_arp("t5", 1, 5, 0, 32'hC0A80A03);
      chk("t5 seek count", 64'(seek_cnt - seek_base), 64'd1);
      chk("t5 target kept", 64'(o_arp_dst_ip), 64'hC0A80A03);

      // 6: reset while waiting for a reply, then a clean hit
      drive_req(32'hC0A80A04);
      to_rel(3); tab(48'h0);
      to_rel(30);
      i_rst = 1'b0;
      #1;
      chk("t6 busy", 64'(o_req_busy), 64'd0);
      chk("t6 pulses", 64'({o_resolve_valid, o_resolve_fail, o_seek_valid, o_arp_req}), 64'd0);
      chk("t6 mac", 64'(o_resolve_mac), 64'd0);
      chk("t6 ips", 64'({o_seek_ip, o_arp_dst_ip}), 64'd0);
      step(2); i_rst = 1'b1; step(2);
      chk("t6 no result", 64'(res_q.size() - res_rd), 64'd0);
      check_arp("t6", 1, 5, 0, 32'hC0A80A04);
      drive_req(32'hC0A80A00);
      expect_res(1'b0, 48'h112233445566, 4);
      to_rel(3); tab(48'h112233445566);
      check_res("t6 rerun", 20);
      check_arp("t6 rerun", 0, 0, 0, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
